// File: rtl/sonata_pkg.sv
// Board-level constants shared by the switch input path: default debounce time
// and the channel layout of the 16-bit switch bus.
package sonata_pkg;

  // 5 ms at a 40 MHz system clock.
  localparam int SwDebounceCyclesDefault = 200_000;

  localparam int SwWidth   = 16;
  localparam int SwUserLsb = 0;
  localparam int SwUserMsb = 7;
  localparam int SwNavLsb  = 8;
  localparam int SwNavMsb  = 12;
  localparam int SwSelLsb  = 13;
  localparam int SwSelMsb  = 15;

endpackage

// File: rtl/switch_debounce_if.sv
// Bundle of switch_debounce data signals. The master drives raw levels,
// the slave (the debouncer) returns debounced levels, edge pulses and busy.
interface switch_debounce_if #(
  parameter int Width = 16
);
  logic [Width-1:0] sw_i;
  logic [Width-1:0] sw_o;
  logic [Width-1:0] rise_o;
  logic [Width-1:0] fall_o;
  logic             busy_o;

  // No handshake: sw_i is a free-running level; all outputs are valid every
  // cycle, and rise_o/fall_o are single-cycle pulses aligned with the sw_o change.
  modport master (output sw_i, input sw_o, rise_o, fall_o, busy_o);
  modport slave  (input sw_i, output sw_o, rise_o, fall_o, busy_o);
endinterface

// File: rtl/switch_debounce_chan.sv
// One switch channel: 2-flop synchroniser, stability counter, debounced level
// and (with SWITCH_DEBOUNCE_EDGE_EN) registered rise/fall pulses.
module switch_debounce_chan #(
  parameter int DebounceCycles = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_i,
  output logic sw_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);
  localparam int              CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] Term = CntW'(DebounceCycles - 1);

  logic [1:0]      sync_q;
  logic            sync;
  logic            q;
  logic            load;
  logic [CntW-1:0] cnt;

  assign sync = sync_q[1];
  // The counter can never pass Term: reaching it with a mismatch loads q instead.
  assign load = (sync != q) && (cnt == Term);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], sw_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (sync == q) begin
      cnt <= '0;
    end else if (load) begin
      q   <= sync;
      cnt <= '0;
    end else begin
      cnt <= cnt + CntW'(1);
    end
  end

  assign sw_o   = q;
  assign busy_o = (cnt != '0);

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic rise_q;
  logic fall_q;

  // Registered on the same edge that loads q, so the pulse lines up with the new level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= load & sync;
      fall_q <= load & ~sync;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/switch_debounce.sv
// Width independent switch debouncers. Define SWITCH_DEBOUNCE_EDGE_EN to get
// rise_o/fall_o pulses; otherwise those ports are tied to 0.
module switch_debounce
  import sonata_pkg::*;
#(
  parameter int Width          = SwWidth,
  parameter int DebounceCycles = SwDebounceCyclesDefault
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] sw_i,
  output logic [Width-1:0] sw_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             busy_o
);
  logic [Width-1:0] busy_vec;

  for (genvar i = 0; i < Width; i++) begin : g_chan
    switch_debounce_chan #(
      .DebounceCycles(DebounceCycles)
    ) u_chan (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .sw_i  (sw_i[i]),
      .sw_o  (sw_o[i]),
      .rise_o(rise_o[i]),
      .fall_o(fall_o[i]),
      .busy_o(busy_vec[i])
    );
  end

  assign busy_o = |busy_vec;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce with Width=4, DebounceCycles=4. Expected output
// events (cycle, level, pulses) are queued by the driver and checked by a monitor.
module tb_switch_debounce;
  localparam int W  = 4;
  localparam int DC = 4;
  localparam int EW = 16 + 3 * W;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  prev_sw = '0;

  switch_debounce_if #(.Width(W)) sw_if ();

  switch_debounce #(
    .Width         (W),
    .DebounceCycles(DC)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .sw_i  (sw_if.sw_i),
    .sw_o  (sw_if.sw_o),
    .rise_o(sw_if.rise_o),
    .fall_o(sw_if.fall_o),
    .busy_o(sw_if.busy_o)
  );

  // Clock / reset / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected pulses are masked off when the edge feature is not built.
  task automatic push_evt(input int c, input logic [W-1:0] sw,
                          input logic [W-1:0] rise, input logic [W-1:0] fall);
    logic [15:0] c16;
    c16 = c[15:0];
    exp_q.push_back({c16, sw, EdgeEn ? rise : '0, EdgeEn ? fall : '0});
  endtask

  task automatic drive(input logic [W-1:0] v, output int d);
    @(negedge clk);
    sw_if.sw_i = v;
    d = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any level change or pulse is an output event to match.
  always @(negedge clk) begin
    logic [EW-1:0] act;
    logic [EW-1:0] exp;
    if (!rst_ni) begin
      prev_sw = sw_if.sw_o;
    end else if (sw_if.sw_o !== prev_sw || sw_if.rise_o !== '0 || sw_if.fall_o !== '0) begin
      act = {cyc[15:0], sw_if.sw_o, sw_if.rise_o, sw_if.fall_o};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: cycle %0d sw_o=%b rise_o=%b fall_o=%b, none expected",
                 cyc, sw_if.sw_o, sw_if.rise_o, sw_if.fall_o);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL event: got cycle %0d sw=%b rise=%b fall=%b, expected cycle %0d sw=%b rise=%b fall=%b",
                   act[EW-1 -: 16], act[3*W-1 -: W], act[2*W-1 -: W], act[W-1:0],
                   exp[EW-1 -: 16], exp[3*W-1 -: W], exp[2*W-1 -: W], exp[W-1:0]);
        end
      end
      prev_sw = sw_if.sw_o;
    end
  end

  initial begin
    int d;
    int r;
    sw_if.sw_i = '0;

    // Reset state
    idle(3);
    check("reset_sw_o", 32'(sw_if.sw_o), 0);
    check("reset_rise_o", 32'(sw_if.rise_o), 0);
    check("reset_fall_o", 32'(sw_if.fall_o), 0);
    check("reset_busy_o", 32'(sw_if.busy_o), 0);
    rst_ni = 1'b1;
    idle(2);

    // Clean press on channel 0: level and pulse at drive+6, busy on drive+3..+5
    drive(4'b0001, d);
    push_evt(d + DC + 2, 4'b0001, 4'b0001, 4'b0000);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check($sformatf("press_busy_%0d", i), 32'(sw_if.busy_o), 32'(i >= 3 && i <= 5));
    end
    idle(4);

    // Bounce on channel 1: 3 high, 1 low, then steady high
    drive(4'b0011, d);
    idle(3);
    sw_if.sw_i = 4'b0001;
    idle(1);
    sw_if.sw_i = 4'b0011;
    d = cyc;
    push_evt(d + DC + 2, 4'b0011, 4'b0010, 4'b0000);
    idle(4);
    check("bounce_sw_o_held", 32'(sw_if.sw_o), 32'(4'b0001));
    idle(6);

    // Release both, then simultaneous rise on channels 1 and 3
    drive(4'b0000, d);
    push_evt(d + DC + 2, 4'b0000, 4'b0000, 4'b0011);
    idle(10);
    drive(4'b1010, d);
    push_evt(d + DC + 2, 4'b1010, 4'b1010, 4'b0000);
    idle(10);
    check("simul_sw_o", 32'(sw_if.sw_o), 32'(4'b1010));

    // Reset while channel 2 is mid-count (cnt=2)
    drive(4'b1110, d);
    idle(4);
    check("midcount_busy", 32'(sw_if.busy_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    check("midreset_sw_o", 32'(sw_if.sw_o), 0);
    check("midreset_rise_o", 32'(sw_if.rise_o), 0);
    check("midreset_fall_o", 32'(sw_if.fall_o), 0);
    check("midreset_busy_o", 32'(sw_if.busy_o), 0);
    idle(2);
    rst_ni = 1'b1;
    r = cyc;
    push_evt(r + DC + 2, 4'b1110, 4'b1110, 4'b0000);
    idle(10);

    // Channel 0 on, then released
    drive(4'b1111, d);
    push_evt(d + DC + 2, 4'b1111, 4'b0001, 4'b0000);
    idle(10);
    drive(4'b1110, d);
    push_evt(d + DC + 2, 4'b1110, 4'b0000, 4'b0001);
    idle(4);
    check("release_sw_o_held", 32'(sw_if.sw_o), 32'(4'b1111));

    // Drain with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    idle(3);
    check("queue_drained", 32'(exp_q.size()), 0);
    check("final_sw_o", 32'(sw_if.sw_o), 32'(4'b1110));
    check("final_busy_o", 32'(sw_if.busy_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
